serial_adder: RTL and testbench

- Bit-serial WIDTH-bit adder built around the team's existing single-bit full adder cell.
- Sits directly upstream of that cell:
  - feeds it one operand bit pair per clock, LSB first;
  - registers its carry output and feeds it back as the next carry-in.
- Start/busy/done handshake, so a controller can issue multi-bit additions at low area cost.

---
 rtl/serial_adder_pkg.sv | 25 ++
 rtl/serial_adder_if.sv | 41 ++++
 rtl/serial_adder_fulladder.sv | 22 ++
 rtl/serial_adder.sv | 147 ++++++++++++++
 tb/tb_serial_adder.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder_pkg
//  Purpose  : Shared types and helpers for the bit-serial adder slice
//             (FSM state encoding, counter width helper).
//  Revision : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

    // Controller state encoding.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bit counter width: enough to count WIDTH cycles, never below one bit.
    function automatic int cnt_width(input int width);
        int w;
        w = $clog2(width);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : serial_adder_pkg
`default_nettype wire

// File: rtl/serial_adder_if.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder_if
//  Purpose  : Start/busy/done handshake and operand/result bundle between a
//             controller (master) and the bit-serial adder (slave).
//             Optional macro SERIAL_ADDER_OVF_EN adds the ovf result flag.
//  Revision : 1.0 - initial release
// ============================================================================
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, a, b, cin,
`ifdef SERIAL_ADDER_OVF_EN
        input  ovf,
`endif
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
`ifdef SERIAL_ADDER_OVF_EN
        output ovf,
`endif
        output busy, done, sum, cout
    );

endinterface : serial_adder_if
`default_nettype wire

// File: rtl/serial_adder_fulladder.sv
`default_nettype none
// ============================================================================
//  Module   : fulladder
//  Purpose  : Single-bit full adder cell (combinational).
//  Revision : 1.0 - initial release
// ============================================================================
module fulladder (
    input  wire logic a,
    input  wire logic b,
    input  wire logic ci,
    output logic      s,
    output logic      co
);

    // Sum and majority carry of the three input bits.
    always_comb begin
        s  = a ^ b ^ ci;
        co = (a & b) | (a & ci) | (b & ci);
    end

endmodule : fulladder
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder
//  Purpose  : Bit-serial WIDTH-bit adder. Feeds one operand bit pair per
//             clock (LSB first) into a single full adder cell and loops its
//             carry back through a register. Start/busy/done handshake.
//             Optional macro SERIAL_ADDER_OVF_EN adds a signed-overflow flag.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    serial_adder_if.slave bus
);

    localparam int                 c_CNT_W    = cnt_width(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    state_t             r_state;
    state_t             w_state_next;
    logic               w_load;
    logic               w_busy;
    logic               w_done;
    logic               w_last;

    // Operand A shift register; produced sum bits enter at the MSB behind
    // the consumed A bits, so after WIDTH shifts it holds the full sum.
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   w_a_next;
    logic [WIDTH-1:0]   r_b_sh;
    logic               r_carry;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               w_x;
    logic               w_y;

    fulladder u_fa (
        .a  (r_a_sh[0]),
        .b  (r_b_sh[0]),
        .ci (r_carry),
        .s  (w_x),
        .co (w_y)
    );

    assign w_last = (r_cnt == c_CNT_LAST);

    generate
        if (WIDTH == 1) begin : g_w1
            assign w_a_next = w_x;
        end else begin : g_wn
            assign w_a_next = {w_x, r_a_sh[WIDTH-1:1]};
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_load       = 1'b1;
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_done       = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Bit datapath: load operands on start, shift one bit per SHIFT cycle,
    // capture the result on the final bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_load) begin
            r_a_sh  <= bus.a;
            r_b_sh  <= bus.b;
            r_carry <= bus.cin;
            r_cnt   <= '0;
        end else if (w_busy) begin
            r_a_sh  <= w_a_next;
            r_b_sh  <= r_b_sh >> 1;
            r_carry <= w_y;
            r_cnt   <= r_cnt + c_CNT_ONE;
            if (w_last) begin
                r_sum  <= w_a_next;
                r_cout <= w_y;
            end
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic r_ovf;

    // Signed overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_busy && w_last) begin
            r_ovf <= r_carry ^ w_y;
        end
    end

    assign bus.ovf = r_ovf;
`endif

    assign bus.busy = w_busy;
    assign bus.done = w_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;

endmodule : serial_adder
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_adder
//  Purpose  : Self-checking bench for serial_adder (WIDTH=8 and WIDTH=1).
//             Honours SERIAL_ADDER_OVF_EN when defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    serial_adder_if #(.WIDTH(8)) if8 ();
    serial_adder_if #(.WIDTH(1)) if1 ();

    serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8.slave)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one addition on the WIDTH=8 instance and return the number of
    // cycles from the accepted start edge to the done pulse (50 = timeout).
    task automatic run_add8(input logic [7:0] ta, input logic [7:0] tb_v,
                            input logic tc, output int lat);
        @(negedge clk);
        if8.a     = ta;
        if8.b     = tb_v;
        if8.cin   = tc;
        if8.start = 1'b1;
        @(posedge clk);
        #1;
        if8.start = 1'b0;
        if8.a     = ~ta;
        if8.b     = ~tb_v;
        if8.cin   = ~tc;
        lat = 0;
        while (lat < 50) begin
            @(negedge clk);
            lat++;
            if (if8.done) break;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({if8.busy, if8.done, if8.sum, if8.cout} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_w8: busy/done/sum/cout got %b expected all zero",
                     {if8.busy, if8.done, if8.sum, if8.cout});
        end
        n_checks++;
        if ({if1.busy, if1.done, if1.sum, if1.cout} !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_w1: busy/done/sum/cout got %b expected all zero",
                     {if1.busy, if1.done, if1.sum, if1.cout});
        end
`ifdef SERIAL_ADDER_OVF_EN
        n_checks++;
        if (if8.ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ovf: got %b expected 0", if8.ovf);
        end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        run_add8(8'h5A, 8'h3C, 1'b0, lat);
        n_checks++;
        if (lat !== 9) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d expected 9", lat);
        end
        n_checks++;
        if ({if8.cout, if8.sum} !== 9'h096) begin
            n_fail++;
            $display("FAIL basic_sum: got cout=%b sum=%h expected cout=0 sum=96",
                     if8.cout, if8.sum);
        end
`ifdef SERIAL_ADDER_OVF_EN
        n_checks++;
        if (if8.ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_ovf: got %b expected 1", if8.ovf);
        end
`endif
    endtask

    task automatic test_carry_wrap();
        int lat;
        run_add8(8'hFF, 8'h01, 1'b0, lat);
        n_checks++;
        if ({if8.cout, if8.sum} !== 9'h100 || lat !== 9) begin
            n_fail++;
            $display("FAIL wrap_ff_01: got cout=%b sum=%h lat=%0d expected cout=1 sum=00 lat=9",
                     if8.cout, if8.sum, lat);
        end
`ifdef SERIAL_ADDER_OVF_EN
        n_checks++;
        if (if8.ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_ff_01_ovf: got %b expected 0", if8.ovf);
        end
`endif
        run_add8(8'h80, 8'h80, 1'b0, lat);
        n_checks++;
        if ({if8.cout, if8.sum} !== 9'h100 || lat !== 9) begin
            n_fail++;
            $display("FAIL wrap_80_80: got cout=%b sum=%h lat=%0d expected cout=1 sum=00 lat=9",
                     if8.cout, if8.sum, lat);
        end
`ifdef SERIAL_ADDER_OVF_EN
        n_checks++;
        if (if8.ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_80_80_ovf: got %b expected 1", if8.ovf);
        end
`endif
    endtask

    task automatic test_carry_in();
        int lat;
        run_add8(8'h00, 8'h00, 1'b1, lat);
        n_checks++;
        if ({if8.cout, if8.sum} !== 9'h001 || lat !== 9) begin
            n_fail++;
            $display("FAIL cin_00_00: got cout=%b sum=%h lat=%0d expected cout=0 sum=01 lat=9",
                     if8.cout, if8.sum, lat);
        end
        run_add8(8'hFF, 8'hFF, 1'b1, lat);
        n_checks++;
        if ({if8.cout, if8.sum} !== 9'h1FF || lat !== 9) begin
            n_fail++;
            $display("FAIL cin_ff_ff: got cout=%b sum=%h lat=%0d expected cout=1 sum=ff lat=9",
                     if8.cout, if8.sum, lat);
        end
`ifdef SERIAL_ADDER_OVF_EN
        n_checks++;
        if (if8.ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL cin_ff_ff_ovf: got %b expected 0", if8.ovf);
        end
`endif
    endtask

    task automatic test_start_while_busy();
        int         ndone;
        int         dlat;
        logic [7:0] dsum;
        logic       busy3;
        ndone = 0;
        dlat  = 0;
        dsum  = '0;
        busy3 = 1'b0;
        @(negedge clk);
        if8.a     = 8'h12;
        if8.b     = 8'h34;
        if8.cin   = 1'b0;
        if8.start = 1'b1;
        @(posedge clk);
        #1;
        if8.start = 1'b0;
        for (int cyc = 1; cyc <= 25; cyc++) begin
            @(negedge clk);
            if (if8.done) begin
                ndone++;
                if (ndone == 1) begin
                    dlat = cyc;
                    dsum = if8.sum;
                end
            end
            if (cyc == 3) begin
                busy3     = if8.busy;
                if8.a     = 8'h77;
                if8.b     = 8'h11;
                if8.start = 1'b1;
            end
            if (cyc == 4) if8.start = 1'b0;
        end
        n_checks++;
        if (busy3 !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_during_shift: got %b expected 1", busy3);
        end
        n_checks++;
        if (ndone !== 1 || dlat !== 9 || dsum !== 8'h46) begin
            n_fail++;
            $display("FAIL start_while_busy: got done_count=%0d lat=%0d sum=%h expected 1/9/46",
                     ndone, dlat, dsum);
        end
        n_checks++;
        if (if8.sum !== 8'h46) begin
            n_fail++;
            $display("FAIL sum_hold: got %h expected 46", if8.sum);
        end
    endtask

    task automatic test_back_to_back();
        int ndone;
        int t1;
        int t2;
        ndone = 0;
        t1    = 0;
        t2    = 0;
        @(negedge clk);
        if8.a     = 8'h01;
        if8.b     = 8'h02;
        if8.cin   = 1'b0;
        if8.start = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (if8.done) begin
                ndone++;
                if (ndone == 1) t1 = cyc;
                if (ndone == 2) t2 = cyc;
            end
        end
        if8.start = 1'b0;
        n_checks++;
        if (ndone !== 4 || t1 !== 9 || t2 !== 19) begin
            n_fail++;
            $display("FAIL back_to_back: got count=%0d first=%0d second=%0d expected 4/9/19",
                     ndone, t1, t2);
        end
        n_checks++;
        if ({if8.cout, if8.sum} !== 9'h003) begin
            n_fail++;
            $display("FAIL back_to_back_sum: got cout=%b sum=%h expected 0/03",
                     if8.cout, if8.sum);
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset_midop();
        int   ndone;
        int   lat;
        logic busy_pre;
        ndone = 0;
        @(negedge clk);
        if8.a     = 8'h33;
        if8.b     = 8'h44;
        if8.cin   = 1'b0;
        if8.start = 1'b1;
        @(posedge clk);
        #1;
        if8.start = 1'b0;
        repeat (5) @(negedge clk);
        busy_pre = if8.busy;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if (busy_pre !== 1'b1) begin
            n_fail++;
            $display("FAIL midop_busy_before: got %b expected 1", busy_pre);
        end
        n_checks++;
        if ({if8.busy, if8.done, if8.sum, if8.cout} !== 11'd0) begin
            n_fail++;
            $display("FAIL midop_reset: busy/done/sum/cout got %b expected all zero",
                     {if8.busy, if8.done, if8.sum, if8.cout});
        end
        for (int cyc = 0; cyc < 15; cyc++) begin
            @(negedge clk);
            if (if8.done) ndone++;
        end
        n_checks++;
        if (ndone !== 0) begin
            n_fail++;
            $display("FAIL midop_no_done: got %0d done pulses expected 0", ndone);
        end
        run_add8(8'h0F, 8'h01, 1'b0, lat);
        n_checks++;
        if ({if8.cout, if8.sum} !== 9'h010 || lat !== 9) begin
            n_fail++;
            $display("FAIL midop_restart: got cout=%b sum=%h lat=%0d expected 0/10/9",
                     if8.cout, if8.sum, lat);
        end
    endtask

    task automatic test_width1();
        logic [1:0] exp_tab [8];
        logic [2:0] v;
        int         lat;
        exp_tab = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            @(negedge clk);
            @(negedge clk);
            if1.a     = v[2];
            if1.b     = v[1];
            if1.cin   = v[0];
            if1.start = 1'b1;
            @(posedge clk);
            #1;
            if1.start = 1'b0;
            lat = 0;
            while (lat < 10) begin
                @(negedge clk);
                lat++;
                if (if1.done) break;
            end
            n_checks++;
            if ({if1.cout, if1.sum} !== exp_tab[i] || lat !== 2) begin
                n_fail++;
                $display("FAIL w1_abc_%0d: got {cout,sum}=%b lat=%0d expected %b lat=2",
                         i, {if1.cout, if1.sum}, lat, exp_tab[i]);
            end
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        if8.start = 1'b0;
        if8.a     = '0;
        if8.b     = '0;
        if8.cin   = 1'b0;
        if1.start = 1'b0;
        if1.a     = '0;
        if1.b     = '0;
        if1.cin   = 1'b0;

        test_reset();
        test_basic();
        test_carry_wrap();
        test_carry_in();
        test_start_while_busy();
        test_back_to_back();
        test_reset_midop();
        test_width1();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_serial_adder
`default_nettype wire
